xgmii_rx_framer: RTL and testbench
==================================

Name: xgmii_rx_framer

Overview:
- Sits directly downstream of xgmii2fifo72 on each 10G receive path. Consumes its 72-bit {rxc,rxd} word stream and writes only frame words into a per-port frame FIFO.
- Realigns lane-4 starts so every frame begins in lane 0, and drops frames the FIFO cannot hold.
- Bounds runaway or malformed frames with an abort word, and keeps frame, drop and error counters for the LEDs and debug.

Parameters:
- MAX_WORDS, 1200, maximum 72-bit words per frame, including the SOF word and the word holding FD; exceeding it aborts the frame.
- CNT_W, 32, width of each statistics counter.

Ports:
- sys_clk  in  1  system/XGMII clock (156.25 MHz).
- sys_rst  in  1  asynchronous, active-high reset.
- xgmii_rx  in  72  {rxc[7:0], rxd[63:0]} from xgmii2fifo72; lane n = rxd[8n+7:8n], control bit rxc[n].
- fifo_din  out  72  word to frame FIFO, same {rxc,rxd} format.
- fifo_wr_en  out  1  write strobe, one word per cycle.
- fifo_full  in  1  FIFO full.
- fifo_half  in  1  FIFO at least half full; used for frame admission.
- frame_cnt  out  CNT_W  frames fully written.
- drop_cnt  out  CNT_W  frames refused at SOF or truncated by full.
- err_cnt  out  CNT_W  protocol errors: FE seen, SOF inside frame, oversize.

Behaviour:
- Reset values: fifo_wr_en=0, fifo_din=72'h FF_0707070707070707, all counters 0, state IDLE, align=0, hold register = idle pattern.
- Control codes: 07 idle, FB start, FD terminate, FE error.
- SOF0: rxc[0]=1 and lane0=FB. SOF4: rxc[4]=1 and lane4=FB; SOF4 is recognised only when no FD is present in lanes 0-3.
- TERM: any lane n with rxc[n]=1 and lane n=FD.
- IDLE state:
  - No writes.
  - On SOF0 or SOF4: if fifo_half=1 or fifo_full=1, drop_cnt++ and go to DROP.
  - Otherwise go to FRAME with align = (SOF4).
- FRAME, align=0:
  - Each input word is written unchanged one cycle later: fifo_din registered, latency 1.
  - The word containing TERM is written, then frame_cnt++ and go to IDLE.
- FRAME, align=1:
  - The high 4 lanes of each word are held.
  - Output word = {rxc: cur[3:0],hold[7:4]; rxd: cur lanes0-3 in out lanes4-7, hold lanes4-7 in out lanes0-3}.
  - The first write occurs 2 cycles after the SOF4 word enters.
  - If TERM lies in cur lanes 0-3, that output is the last word.
  - If TERM lies in lanes 4-7, one extra flush word is written: {hold lanes4-7, four 07 idle lanes, rxc=F_ | hold ctl}.
  - Then frame_cnt++ and go to IDLE.
- Word counter counts written words; it resets at each SOF.
- If FE appears in any control lane inside a frame: err_cnt++ (once per frame) and the word is forwarded unchanged.
- SOF while in FRAME, or the word count reaching MAX_WORDS without TERM:
  - err_cnt++.
  - Write the abort word in place of the current word: rxc=FF, lane0=FE, lane1=FD, lanes2-7=07.
  - Go to DROP (SOF case) or IDLE (oversize, when the current word has TERM), else DROP.
  - The aborted frame is not counted in frame_cnt.
- fifo_full=1 in a cycle where a write is due:
  - Suppress the write, drop_cnt++, go to DROP.
  - Frames are admitted only below half, so this must not occur with a FIFO depth of at least 2*MAX_WORDS.
- DROP state: no writes; return to IDLE on the cycle TERM is seen.
- Simultaneous TERM and SOF in the same word (lane-0 FD then lane-4 FB):
  - Close the current frame normally.
  - Handle SOF4 in the same cycle: the next state is FRAME with align=1, subject to the half check.
- Counters wrap modulo 2^CNT_W.
- Reset asserted mid-frame: all state clears immediately. Output resumes only at the next SOF seen after deassertion; the partial frame is not terminated by this block.

Test Plan:
- Aligned frame, 8 words, FD in lane 3 of word 8, half=0 -> 8 writes identical to input words, first write 1 cycle after SOF; frame_cnt=1.
- SOF4 frame, lane4=FB, FD in lane 6 of word 5 -> first output lane0=FB, 2-cycle latency, 6 writes including flush word whose lane2=FD; frame_cnt=1.
- fifo_half=1 at SOF0, 20-word frame -> zero writes, drop_cnt=1; next frame with half=0 is written normally.
- MAX_WORDS=16, 40-word frame -> 15 data writes plus abort word FF_0707070707_07FDFE; err_cnt=1; remaining words discarded until FD.
- FE in lane 2 of word 3 of a 6-word frame -> all 6 words written unchanged; err_cnt=1, frame_cnt=1.
- sys_rst pulsed at word 4 of a 10-word frame -> wr_en=0 and counters 0 immediately; no writes until the next FB.

Source files
------------

// File: rtl/xgmii_rx_framer.sv
// rtl/xgmii_rx_framer.sv - XGMII receive framer: frame extraction, lane-4 realignment, abort and stats
// Only frame words reach the FIFO; SOF4 frames are shifted by four lanes so FB always lands in lane 0.
module xgmii_rx_framer #(
  parameter int MAX_WORDS = 1200,
  parameter int CNT_W     = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [71:0]      xgmii_rx,
  output logic [71:0]      fifo_din,
  output logic             fifo_wr_en,
  input  logic             fifo_full,
  input  logic             fifo_half,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [71:0]     IDLE_WORD  = 72'hFF_0707070707070707;
  localparam logic [71:0]     ABORT_WORD = 72'hFF_070707070707FDFE;
  localparam int              WC_W       = $clog2(MAX_WORDS + 1);
  localparam logic [WC_W-1:0] WC_LAST    = WC_W'(MAX_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_FLUSH, S_DROP} state_t;

  state_t           state_q, state_d;
  logic             align_q, align_d;
  logic             fe_seen_q, fe_seen_d;
  logic             wr_en_q, wr_en_d;
  logic [35:0]      hold_q, hold_d;
  logic [71:0]      din_q, din_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0] frame_q, frame_d, drop_q, drop_d, err_q, err_d;

  logic [7:0]  is_fd, is_fe;
  logic        sof0, sof4_raw, sof4, term_lo, term_hi, term;
  logic [71:0] shifted, flush_word, out_word;
  logic        out_term, admit0, admit4, frame_inc, drop_inc;
  logic [1:0]  err_inc;

  always_comb begin
    is_fd = '0;
    is_fe = '0;
    for (int n = 0; n < 8; n++) begin
      is_fd[n] = xgmii_rx[64+n] && (xgmii_rx[8*n +: 8] == 8'hFD);
      is_fe[n] = xgmii_rx[64+n] && (xgmii_rx[8*n +: 8] == 8'hFE);
    end
  end

  assign sof0     = xgmii_rx[64] && (xgmii_rx[7:0] == 8'hFB);
  assign sof4_raw = xgmii_rx[68] && (xgmii_rx[39:32] == 8'hFB);
  assign term_lo  = |is_fd[3:0];
  assign term_hi  = |is_fd[7:4];
  assign term     = term_lo || term_hi;
  assign sof4     = sof4_raw && !term_lo;

  // hold_q = {ctl[7:4], rxd[63:32]} of the previous word
  assign shifted    = {xgmii_rx[67:64], hold_q[35:32], xgmii_rx[31:0], hold_q[31:0]};
  assign flush_word = {4'hF, hold_q[35:32], 32'h07070707, hold_q[31:0]};
  assign out_word   = align_q ? shifted : xgmii_rx;
  assign out_term   = align_q ? term_lo : term;

  always_comb begin
    state_d   = state_q;
    align_d   = align_q;
    fe_seen_d = fe_seen_q;
    hold_d    = {xgmii_rx[71:68], xgmii_rx[63:32]};
    wr_en_d   = 1'b0;
    din_d     = din_q;
    wcnt_d    = wcnt_q;
    frame_inc = 1'b0;
    drop_inc  = 1'b0;
    err_inc   = 2'd0;
    admit0    = 1'b0;
    admit4    = 1'b0;
    case (state_q)
      S_IDLE: begin
        admit0 = sof0;
        admit4 = !sof0 && sof4;
      end
      S_FRAME: begin
        if (|is_fe && !fe_seen_q) begin
          fe_seen_d = 1'b1;
          err_inc   = err_inc + 2'd1;
        end
        if (fifo_full) begin
          drop_inc = 1'b1;
          state_d  = term ? S_IDLE : S_DROP;
        end else if (sof0 || sof4 || (wcnt_q == WC_LAST && !out_term)) begin
          err_inc = err_inc + 2'd1;
          wr_en_d = 1'b1;
          din_d   = ABORT_WORD;
          state_d = term ? S_IDLE : S_DROP;
        end else begin
          wr_en_d = 1'b1;
          din_d   = out_word;
          wcnt_d  = wcnt_q + WC_W'(1);
          if (out_term) begin
            frame_inc = 1'b1;
            state_d   = S_IDLE;
            admit4    = term_lo && sof4_raw;
          end else if (align_q && term_hi) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_IDLE;
        if (fifo_full) begin
          drop_inc = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          din_d     = flush_word;
          frame_inc = 1'b1;
        end
      end
      S_DROP: begin
        if (term) begin
          state_d = S_IDLE;
          admit4  = term_lo && sof4_raw;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Admission: a back-to-back FD/FB word closes one frame and opens the next here
    if (admit0 || admit4) begin
      fe_seen_d = 1'b0;
      wcnt_d    = '0;
      if (fifo_half || fifo_full) begin
        drop_inc = 1'b1;
        state_d  = S_DROP;
      end else begin
        state_d = S_FRAME;
        align_d = admit4;
        if (admit0 ? |is_fe : |is_fe[7:4]) begin
          fe_seen_d = 1'b1;
          err_inc   = err_inc + 2'd1;
        end
        if (admit0) begin
          wr_en_d = 1'b1;
          din_d   = xgmii_rx;
          wcnt_d  = WC_W'(1);
        end
      end
    end

    frame_d = frame_q + CNT_W'(frame_inc);
    drop_d  = drop_q + CNT_W'(drop_inc);
    err_d   = err_q + CNT_W'(err_inc);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      align_q   <= 1'b0;
      fe_seen_q <= 1'b0;
      wr_en_q   <= 1'b0;
      hold_q    <= {4'hF, 32'h07070707};
      din_q     <= IDLE_WORD;
      wcnt_q    <= '0;
      frame_q   <= '0;
      drop_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      align_q   <= align_d;
      fe_seen_q <= fe_seen_d;
      wr_en_q   <= wr_en_d;
      hold_q    <= hold_d;
      din_q     <= din_d;
      wcnt_q    <= wcnt_d;
      frame_q   <= frame_d;
      drop_q    <= drop_d;
      err_q     <= err_d;
    end
  end

  assign fifo_din   = din_q;
  assign fifo_wr_en = wr_en_q;
  assign frame_cnt  = frame_q;
  assign drop_cnt   = drop_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_xgmii_rx_framer.sv
// tb/tb_xgmii_rx_framer.sv - directed and randomized frames checked against a lane-stream reference model
module tb_xgmii_rx_framer;

  localparam int          MAXW    = 16;
  localparam logic [71:0] IDLE_W  = 72'hFF_0707070707070707;
  localparam logic [71:0] ABORT_W = 72'hFF_070707070707FDFE;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [71:0] xgmii_rx;
  logic [71:0] fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic        fifo_half;
  logic [31:0] frame_cnt, drop_cnt, err_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int sof_cyc = 0;
  int m_frame = 0, m_drop = 0, m_err = 0;

  logic [71:0] fw[$];
  logic [71:0] exp_q[$];
  logic [71:0] got_q[$];
  int          got_cyc[$];

  xgmii_rx_framer #(.MAX_WORDS(MAXW), .CNT_W(32)) dut (
    .sys_clk   (clk),
    .sys_rst   (sys_rst),
    .xgmii_rx  (xgmii_rx),
    .fifo_din  (fifo_din),
    .fifo_wr_en(fifo_wr_en),
    .fifo_full (fifo_full),
    .fifo_half (fifo_half),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      got_q.push_back(fifo_din);
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] put(input logic [71:0] w, input int n, input logic c, input logic [7:0] b);
    logic [71:0] r;
    r = w;
    r[64+n] = c;
    r[8*n +: 8] = b;
    return r;
  endfunction

  task automatic build(input int n, input bit s4, input int fd_lane, input int fe_word, input int fe_lane);
    logic [71:0] w;
    fw.delete();
    for (int k = 0; k < n; k++) begin
      w = {8'h00, $urandom(), $urandom()};
      if (k == 0) begin
        if (s4) begin
          for (int l = 0; l < 4; l++) w = put(w, l, 1'b1, 8'h07);
          w = put(w, 4, 1'b1, 8'hFB);
        end else begin
          w = put(w, 0, 1'b1, 8'hFB);
        end
      end
      if (k == n - 1) begin
        w = put(w, fd_lane, 1'b1, 8'hFD);
        for (int l = fd_lane + 1; l < 8; l++) w = put(w, l, 1'b1, 8'h07);
      end
      if (k == fe_word) w = put(w, fe_lane, 1'b1, 8'hFE);
      fw.push_back(w);
    end
  endtask

  // Frame as a lane stream starting at FB, cut into 8-lane words up to the word holding FD
  task automatic model(input bit s4, input bit hf, input int full_at, input int sof_at);
    logic [8:0]  lanes[$];
    logic [71:0] chunks[$];
    logic [71:0] w;
    bit          fe, done;
    int          idx;
    fe = 1'b0;
    for (int k = 0; k < fw.size(); k++) begin
      w = fw[k];
      for (int l = 0; l < 8; l++) begin
        if (w[64+l] && w[8*l +: 8] == 8'hFE) fe = 1'b1;
        if (!(s4 && k == 0 && l < 4)) lanes.push_back({w[64+l], w[8*l +: 8]});
      end
    end
    idx = 0;
    done = 1'b0;
    while (!done) begin
      w = IDLE_W;
      for (int j = 0; j < 8; j++) begin
        if (idx < lanes.size()) begin
          w[64+j] = lanes[idx][8];
          w[8*j +: 8] = lanes[idx][7:0];
          if (lanes[idx] == 9'h1FD) done = 1'b1;
          idx++;
        end
      end
      chunks.push_back(w);
      if (idx >= lanes.size()) done = 1'b1;
    end
    if (hf) begin
      m_drop++;
    end else begin
      if (fe) m_err++;
      if (full_at >= 0) begin
        for (int k = 0; k < full_at; k++) exp_q.push_back(chunks[k]);
        m_drop++;
      end else if (sof_at >= 0) begin
        for (int k = 0; k < sof_at; k++) exp_q.push_back(chunks[k]);
        exp_q.push_back(ABORT_W);
        m_err++;
      end else if (chunks.size() > MAXW) begin
        for (int k = 0; k < MAXW - 1; k++) exp_q.push_back(chunks[k]);
        exp_q.push_back(ABORT_W);
        m_err++;
      end else begin
        for (int k = 0; k < chunks.size(); k++) exp_q.push_back(chunks[k]);
        m_frame++;
      end
    end
  endtask

  task automatic send_frame(input bit hf, input int full_at);
    fifo_half = hf;
    for (int k = 0; k < fw.size(); k++) begin
      @(posedge clk);
      #1;
      xgmii_rx = fw[k];
      fifo_full = (k == full_at);
      if (k == 0) sof_cyc = cyc;
    end
    @(posedge clk);
    #1;
    xgmii_rx = IDLE_W;
    fifo_full = 1'b0;
    fifo_half = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int lat);
    chk({tag, " count"}, 72'(got_q.size()), 72'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk($sformatf("%s w%0d", tag, k), got_q[k], exp_q[k]);
    if (exp_q.size() > 0 && got_q.size() > 0)
      chk({tag, " latency"}, 72'(got_cyc[0] - sof_cyc), 72'(lat));
    chk({tag, " frame_cnt"}, 72'(frame_cnt), 72'(m_frame));
    chk({tag, " drop_cnt"}, 72'(drop_cnt), 72'(m_drop));
    chk({tag, " err_cnt"}, 72'(err_cnt), 72'(m_err));
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    int n, fd, few, fel;
    bit s4, hf;
    sys_rst = 1'b1;
    xgmii_rx = IDLE_W;
    fifo_full = 1'b0;
    fifo_half = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset wr_en", 72'(fifo_wr_en), 72'(0));
    chk("reset din", fifo_din, IDLE_W);
    chk("reset frame_cnt", 72'(frame_cnt), 72'(0));
    chk("reset drop_cnt", 72'(drop_cnt), 72'(0));
    chk("reset err_cnt", 72'(err_cnt), 72'(0));
    sys_rst = 1'b0;

    build(8, 1'b0, 3, -1, 0);
    model(1'b0, 1'b0, -1, -1);
    send_frame(1'b0, -1);
    check_frame("aligned8", 1);

    build(6, 1'b1, 6, -1, 0);
    model(1'b1, 1'b0, -1, -1);
    send_frame(1'b0, -1);
    check_frame("sof4", 2);

    build(20, 1'b0, 5, -1, 0);
    model(1'b0, 1'b1, -1, -1);
    send_frame(1'b1, -1);
    check_frame("half_drop", 1);

    build(7, 1'b0, 2, -1, 0);
    model(1'b0, 1'b0, -1, -1);
    send_frame(1'b0, -1);
    check_frame("after_drop", 1);

    build(40, 1'b0, 5, -1, 0);
    model(1'b0, 1'b0, -1, -1);
    send_frame(1'b0, -1);
    check_frame("oversize", 1);

    build(6, 1'b0, 4, 2, 2);
    model(1'b0, 1'b0, -1, -1);
    send_frame(1'b0, -1);
    check_frame("fe", 1);

    build(10, 1'b0, 1, -1, 0);
    fw[4] = put(fw[4], 0, 1'b1, 8'hFB);
    model(1'b0, 1'b0, -1, 4);
    send_frame(1'b0, -1);
    check_frame("sof_in_frame", 1);

    build(8, 1'b0, 7, -1, 0);
    model(1'b0, 1'b0, 4, -1);
    send_frame(1'b0, 4);
    check_frame("full", 1);

    build(10, 1'b0, 5, -1, 0);
    for (int k = 0; k < 4; k++) exp_q.push_back(fw[k]);
    m_frame = 0;
    m_drop = 0;
    m_err = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      xgmii_rx = fw[k];
      if (k == 0) sof_cyc = cyc;
      if (k == 6) sys_rst = 1'b0;
      if (k == 4) begin
        @(negedge clk);
        #1;
        sys_rst = 1'b1;
        #1;
        chk("midrst wr_en", 72'(fifo_wr_en), 72'(0));
        chk("midrst din", fifo_din, IDLE_W);
        chk("midrst frame_cnt", 72'(frame_cnt), 72'(0));
        chk("midrst err_cnt", 72'(err_cnt), 72'(0));
      end
    end
    @(posedge clk);
    #1;
    xgmii_rx = IDLE_W;
    repeat (3) @(posedge clk);
    #1;
    check_frame("midrst", 1);

    build(6, 1'b0, 0, -1, 0);
    model(1'b0, 1'b0, -1, -1);
    send_frame(1'b0, -1);
    check_frame("post_rst", 1);

    for (int r = 0; r < 16; r++) begin
      n  = $urandom_range(2, 22);
      s4 = 1'($urandom_range(0, 1));
      fd = $urandom_range(0, 7);
      hf = ($urandom_range(0, 4) == 0);
      few = -1;
      fel = 0;
      if (n >= 5 && $urandom_range(0, 2) == 0) begin
        few = $urandom_range(1, 3);
        fel = $urandom_range(0, 7);
      end
      build(n, s4, fd, few, fel);
      model(s4, hf, -1, -1);
      send_frame(hf, -1);
      check_frame($sformatf("rand%0d", r), s4 ? 2 : 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
